// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Wrap-increment of a round-robin pointer over n slots.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set bit of req at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  pick,
  output logic             any_valid
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  // Rotate so that bit 0 of rot corresponds to requester ptr.
  assign dbl = {req, req};
  assign rot = N_REQ'(dbl >> ptr);

  always_comb begin
    any_valid = 1'b0;
    off       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_valid = 1'b1;
        off       = ID_W'(k);
      end
    end
  end

  assign sum  = {1'b0, ptr} + {1'b0, off};
  assign pick = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ)) : ID_W'(sum);

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ valid/ready producers.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     grant_active
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  arb_state_e      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner;
  logic [BC_W-1:0] burst_cnt;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] sel;
  logic            any_valid;
  logic            xfer;
  logic            last_word;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .pick      (pick),
    .any_valid (any_valid)
  );

  // IDLE grants in the same cycle it arbitrates; GRANT ignores everyone but the owner.
  always_comb begin
    sel  = (state == GRANT) ? owner : pick;
    xfer = 1'b0;
    if (!rst && !fifo_full) begin
      xfer = (state == GRANT) ? req_valid[owner] : any_valid;
    end
  end

  assign last_word = (int'(burst_cnt) + 1 == MAX_BURST);

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    grant_id     = '0;
    grant_active = 1'b0;
    if (!rst) begin
      grant_active = (state == GRANT);
      grant_id     = sel;
      fifo_wr_en   = xfer;
      for (int i = 0; i < N_REQ; i++) begin
        if (ID_W'(i) == sel) fifo_wr_data = req_data[i*WIDTH +: WIDTH];
      end
      if (xfer) req_ready = N_REQ'(1) << sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (MAX_BURST == 1) begin
              rr_ptr <= ID_W'(rr_next(32'(pick), N_REQ));
            end else begin
              owner     <= pick;
              burst_cnt <= BC_W'(1);
              state     <= GRANT;
            end
          end
        end
        GRANT: begin
          // Owner went quiet or burst exhausted: hand the pointer to the next requester.
          if (!req_valid[owner] || (xfer && last_word)) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(rr_next(32'(owner), N_REQ));
            burst_cnt <= '0;
          end else if (xfer) begin
            burst_cnt <= burst_cnt + BC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: a MAX_BURST=4 instance driven from a cycle table and a
// MAX_BURST=1 instance feeding an 8-deep FIFO model.
module tb_fifo_wr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_REQ=4, WIDTH=8, MAX_BURST=4
  logic        rst_a, full_a, wr_a, act_a;
  logic [3:0]  valid_a, ready_a;
  logic [31:0] data_a;
  logic [7:0]  wdata_a;
  logic [1:0]  gid_a;

  // Instance B: N_REQ=4, WIDTH=8, MAX_BURST=1
  logic        rst_b, full_b, wr_b, act_b;
  logic [3:0]  valid_b, ready_b;
  logic [31:0] data_b;
  logic [7:0]  wdata_b;
  logic [1:0]  gid_b;

  fifo_wr_arb #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_data(data_a), .req_ready(ready_a),
    .fifo_full(full_a), .fifo_wr_en(wr_a), .fifo_wr_data(wdata_a), .grant_id(gid_a),
    .grant_active(act_a)
  );

  fifo_wr_arb #(.N_REQ(4), .WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_data(data_b), .req_ready(ready_b),
    .fifo_full(full_b), .fifo_wr_en(wr_b), .fifo_wr_data(wdata_b), .grant_id(gid_b),
    .grant_active(act_b)
  );

  typedef struct {
    bit rst;
    bit full;
    bit wr;
    int id;
    int seq;
    bit act;
  } ent_t;

  ent_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         rem_a[4];
  int         seq_a[4];
  int         seq_b[4];
  logic [7:0] fq[$];
  logic [7:0] expb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic ex(input bit rst, input bit full, input bit wr, input int id, input int seq,
                    input bit act);
    ent_t e;
    e.rst = rst; e.full = full; e.wr = wr; e.id = id; e.seq = seq; e.act = act;
    q.push_back(e);
  endtask

  task automatic drive_a();
    for (int i = 0; i < 4; i++) begin
      valid_a[i]         = (rem_a[i] != 0);
      data_a[i*8 +: 8]   = {4'(i), 4'(seq_a[i])};
    end
  endtask

  task automatic run_a();
    ent_t e;
    while (q.size() > 0) begin
      e      = q.pop_front();
      rst_a  = e.rst;
      full_a = e.full;
      drive_a();
      @(negedge clk);
      check_eq("a_wr_en", 32'(wr_a), 32'(e.wr));
      check_eq("a_active", 32'(act_a), 32'(e.act));
      check_eq("a_ready", 32'(ready_a), e.wr ? (32'd1 << e.id) : 32'd0);
      check_eq("a_wr_vs_hs", 32'(wr_a), 32'(|(valid_a & ready_a)));
      if (e.wr || e.act) check_eq("a_grant_id", 32'(gid_a), 32'(e.id));
      if (e.wr) check_eq("a_wr_data", 32'(wdata_a), 32'({4'(e.id), 4'(e.seq)}));
      if (e.rst) begin
        check_eq("a_rst_data", 32'(wdata_a), 32'd0);
        check_eq("a_rst_gid", 32'(gid_a), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
        if (valid_a[i] && ready_a[i]) begin
          rem_a[i]--;
          seq_a[i]++;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_b(input int ncyc);
    logic [7:0] w;
    int         nread;
    bit         saw_full;
    nread    = 0;
    saw_full = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      full_b  = (fq.size() >= 8);
      valid_b = 4'hF;
      for (int i = 0; i < 4; i++) data_b[i*8 +: 8] = {4'(i), 4'(seq_b[i])};
      if (full_b) saw_full = 1'b1;
      @(negedge clk);
      check_eq("b_no_wr_full", 32'(wr_b & full_b), 32'd0);
      check_eq("b_ready_onehot", 32'($countones(ready_b) <= 1), 32'd1);
      if (wr_b) begin
        fq.push_back(wdata_b);
        for (int i = 0; i < 4; i++) if (ready_b[i]) seq_b[i]++;
      end
      if ((c % 3) == 2 && fq.size() > 0) begin
        w = fq.pop_front();
        nread++;
        if (expb.size() > 0) check_eq("b_order", 32'(w), 32'(expb.pop_front()));
        else check_eq("b_extra_word", 32'(w), 32'hFFFF_FFFF);
      end
      @(posedge clk);
      #1;
    end
    check_eq("b_reads", 32'(nread >= 16), 32'd1);
    check_eq("b_full_seen", 32'(saw_full), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rem_a[i] = 0; seq_a[i] = 0; seq_b[i] = 0;
    end
    rst_a = 1'b1; full_a = 1'b0; valid_a = '0; data_a = '0;
    rst_b = 1'b1; full_b = 1'b0; valid_b = '0; data_b = '0;

    // Reset with requests pending, then 0101 held: bursts 0x4, 2x4, 0x4, no bubbles.
    rem_a[0] = 8;
    rem_a[2] = 4;
    ex(1, 0, 0, 0, 0, 0);
    ex(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      ex(0, 0, 1, (k / 4 == 1) ? 2 : 0, (k / 4 == 2) ? 4 + k % 4 : k % 4, (k % 4) != 0);
    end
    ex(0, 0, 0, 0, 0, 0);
    run_a();
    rst_b = 1'b0;

    // Req1 alone for two words, release bubble, then arbitration resumes at 2.
    rem_a[1] = 2;
    ex(0, 0, 1, 1, 0, 0);
    ex(0, 0, 1, 1, 1, 1);
    ex(0, 0, 0, 1, 0, 1);
    run_a();
    for (int i = 0; i < 4; i++) rem_a[i] = 1;
    ex(0, 0, 1, 2, 4, 0);
    ex(0, 0, 0, 2, 0, 1);
    ex(0, 0, 1, 3, 0, 0);
    ex(0, 0, 0, 3, 0, 1);
    ex(0, 0, 1, 0, 8, 0);
    ex(0, 0, 0, 0, 0, 1);
    ex(0, 0, 1, 1, 2, 0);
    ex(0, 0, 0, 1, 0, 1);
    ex(0, 0, 0, 0, 0, 0);
    run_a();

    // Full for 3 cycles mid-burst: grant held, burst completes afterwards.
    rem_a[0] = 4;
    ex(0, 0, 1, 0, 9, 0);
    ex(0, 0, 1, 0, 10, 1);
    ex(0, 1, 0, 0, 0, 1);
    ex(0, 1, 0, 0, 0, 1);
    ex(0, 1, 0, 0, 0, 1);
    ex(0, 0, 1, 0, 11, 1);
    ex(0, 0, 1, 0, 12, 1);
    ex(0, 0, 0, 0, 0, 0);
    run_a();

    // Full while idle: no lock; same-cycle write once full drops.
    rem_a[3] = 1;
    ex(0, 1, 0, 3, 0, 0);
    ex(0, 1, 0, 3, 0, 0);
    ex(0, 0, 1, 3, 1, 0);
    ex(0, 0, 0, 3, 0, 1);
    ex(0, 0, 0, 0, 0, 0);
    run_a();

    // Reset at burst_cnt=2 abandons the burst; next word comes from IDLE.
    rem_a[0] = 3;
    ex(0, 0, 1, 0, 13, 0);
    ex(0, 0, 1, 0, 14, 1);
    ex(1, 0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 15, 0);
    ex(0, 0, 0, 0, 0, 1);
    ex(0, 0, 0, 0, 0, 0);
    run_a();

    // MAX_BURST=1 strict rotation through an 8-deep FIFO drained every third cycle.
    for (int k = 0; k < 40; k++) expb.push_back({4'(k % 4), 4'(k / 4)});
    run_b(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
